// File: rtl/sc_lane_scheduler.sv
// sc_lane_scheduler: background lane scroll sequencer.
// Each lane counts base ticks at its own speed; expiring lanes post requests that a
// round-robin arbiter turns into one-cycle shift commands on the shared shift bus.
// Also sequences the background clear, start and pause.
module sc_lane_scheduler #(
   parameter int unsigned LANES       = 4,
   parameter int unsigned LANE_W      = 2,
   parameter int unsigned BASE_PERIOD = 8,
   parameter int unsigned CNT_W       = 8
) (
   input  logic              SC_STATEMACHINEBACKG_CLOCK_50,
   input  logic              SC_STATEMACHINEBACKG_RESET_InHigh,
   input  logic              start_InLow,
   input  logic              pause_InLow,
   input  logic              tick_InLow,
   input  logic [1:0]        level_In,
   output logic              clear_OutLow,
   output logic [1:0]        shiftselection_Out,
   output logic [LANE_W-1:0] lane_Out,
   output logic [LANES-1:0]  lane_en_OutLow,
   output logic              busy_Out,
   output logic              overrun_Out
);

   typedef enum logic [2:0] {
      ST_RESET,
      ST_CLEAR,
      ST_IDLE,
      ST_INIT,
      ST_HOLD,
      ST_RUN,
      ST_PAUSE
   } state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt [LANES];
   logic [LANES-1:0]  pending;
   logic [LANES-1:0]  pending_nxt;
   logic [LANES-1:0]  expire;
   logic [LANES-1:0]  grant_oh;
   logic [LANE_W-1:0] rr_ptr;
   logic [LANE_W-1:0] rr_nxt;
   logic [LANE_W-1:0] grant_idx;
   logic [LANE_W-1:0] scan_idx;
   logic              grant_valid;
   logic              run_go;
   logic              tick_hit;
   logic              overrun_hit;

   // Lane i period in base ticks at the given level, never below one tick.
   function automatic logic [CNT_W-1:0] reload_val(input int unsigned idx, input logic [1:0] lvl);
      int unsigned r;
      r = ((idx + 1) * BASE_PERIOD) >> lvl;
      if (r == 0) r = 1;
      return CNT_W'(r);
   endfunction

   // RUN with neither pause nor restart requested: ticks and grants are live.
   assign run_go   = (state == ST_RUN) && pause_InLow && start_InLow;
   assign tick_hit = run_go && !tick_InLow;

   // Lanes whose counter is on its last tick.
   always_comb begin
      expire = '0;
      for (int i = 0; i < LANES; i++) begin
         expire[i] = (cnt[i] == CNT_W'(1));
      end
   end

   // Round-robin search for the first pending lane starting at rr_ptr.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan_idx    = rr_ptr;
      for (int k = 0; k < LANES; k++) begin
         if (!grant_valid && pending[scan_idx]) begin
            grant_valid = 1'b1;
            grant_idx   = scan_idx;
         end
         scan_idx = (scan_idx == LANE_W'(LANES - 1)) ? '0 : scan_idx + LANE_W'(1);
      end
   end

   assign grant_oh = grant_valid ? (LANES'(1) << grant_idx) : '0;
   assign rr_nxt   = (grant_idx == LANE_W'(LANES - 1)) ? '0 : grant_idx + LANE_W'(1);

   // Request bookkeeping: the granted bit drops, fresh expiries join (and merge).
   always_comb begin
      pending_nxt = pending;
      if (state == ST_INIT) begin
         pending_nxt = '0;
      end else if (run_go) begin
         pending_nxt = (pending & ~grant_oh) | (tick_hit ? expire : '0);
      end
   end

   // An expiry onto a request that survives this edge's grant is an overrun.
   assign overrun_hit = tick_hit && (|(expire & pending & ~grant_oh));

   // Sequencer, counters, arbiter state and registered shift outputs.
   always_ff @(posedge SC_STATEMACHINEBACKG_CLOCK_50 or posedge SC_STATEMACHINEBACKG_RESET_InHigh) begin
      if (SC_STATEMACHINEBACKG_RESET_InHigh) begin
         state              <= ST_RESET;
         clear_OutLow       <= 1'b0;
         shiftselection_Out <= 2'b11;
         lane_Out           <= '0;
         lane_en_OutLow     <= '1;
         busy_Out           <= 1'b0;
         overrun_Out        <= 1'b0;
         pending            <= '0;
         rr_ptr             <= '0;
         for (int i = 0; i < LANES; i++) begin
            cnt[i] <= reload_val(i, 2'd0);
         end
      end else begin
         shiftselection_Out <= 2'b11;
         lane_en_OutLow     <= '1;
         pending            <= pending_nxt;
         busy_Out           <= |pending_nxt;
         case (state)
            ST_RESET: begin
               state        <= ST_CLEAR;
               clear_OutLow <= 1'b0;
            end
            ST_CLEAR: begin
               for (int i = 0; i < LANES; i++) begin
                  cnt[i] <= reload_val(i, level_In);
               end
               state        <= ST_IDLE;
               clear_OutLow <= 1'b1;
            end
            ST_IDLE: begin
               if (!start_InLow) begin
                  state        <= ST_INIT;
                  clear_OutLow <= 1'b0;
               end
            end
            ST_INIT: begin
               for (int i = 0; i < LANES; i++) begin
                  cnt[i] <= reload_val(i, level_In);
               end
               overrun_Out  <= 1'b0;
               state        <= ST_HOLD;
               clear_OutLow <= 1'b1;
            end
            ST_HOLD: begin
               if (start_InLow) state <= ST_RUN;
            end
            ST_RUN: begin
               if (!pause_InLow) begin
                  state <= ST_PAUSE;
               end else if (!start_InLow) begin
                  state        <= ST_INIT;
                  clear_OutLow <= 1'b0;
               end else begin
                  if (grant_valid) begin
                     lane_Out           <= grant_idx;
                     lane_en_OutLow     <= ~grant_oh;
                     shiftselection_Out <= grant_idx[0] ? 2'b01 : 2'b10;
                     rr_ptr             <= rr_nxt;
                  end
                  if (tick_hit) begin
                     for (int i = 0; i < LANES; i++) begin
                        if (expire[i]) cnt[i] <= reload_val(i, level_In);
                        else           cnt[i] <= cnt[i] - CNT_W'(1);
                     end
                  end
                  if (overrun_hit) overrun_Out <= 1'b1;
               end
            end
            ST_PAUSE: begin
               if (!start_InLow) begin
                  state        <= ST_INIT;
                  clear_OutLow <= 1'b0;
               end else if (pause_InLow) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state        <= ST_RESET;
               clear_OutLow <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Bench for sc_lane_scheduler: directed scenarios with hand-computed expectations
// plus a randomized run, all outputs compared every cycle to a behavioural model.
module tb_sc_lane_scheduler;

   localparam int unsigned LANES       = 4;
   localparam int unsigned LANE_W      = 2;
   localparam int unsigned BASE_PERIOD = 8;
   localparam int unsigned CNT_W       = 8;

   localparam int P_RST   = 0;
   localparam int P_CLR   = 1;
   localparam int P_IDLE  = 2;
   localparam int P_INIT  = 3;
   localparam int P_HOLD  = 4;
   localparam int P_RUN   = 5;
   localparam int P_PAUSE = 6;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              start_n = 1'b1;
   logic              pause_n = 1'b1;
   logic              tick_n = 1'b1;
   logic [1:0]        level = 2'd0;
   logic              clear_n;
   logic [1:0]        sel;
   logic [LANE_W-1:0] lane;
   logic [LANES-1:0]  en_n;
   logic              busy;
   logic              ovr;

   int errors = 0;
   int checks = 0;

   sc_lane_scheduler #(
      .LANES(LANES), .LANE_W(LANE_W), .BASE_PERIOD(BASE_PERIOD), .CNT_W(CNT_W)
   ) dut (
      .SC_STATEMACHINEBACKG_CLOCK_50    (clk),
      .SC_STATEMACHINEBACKG_RESET_InHigh(rst),
      .start_InLow       (start_n),
      .pause_InLow       (pause_n),
      .tick_InLow        (tick_n),
      .level_In          (level),
      .clear_OutLow      (clear_n),
      .shiftselection_Out(sel),
      .lane_Out          (lane),
      .lane_en_OutLow    (en_n),
      .busy_Out          (busy),
      .overrun_Out       (ovr)
   );

   always #10 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_phase;
   int m_cnt [LANES];
   bit m_pend [LANES];
   int m_rr;
   int e_clr, e_sel, e_lane, e_en, e_busy, e_ovr;

   function automatic int reload_of(input int ln, input int lvl);
      int r;
      r = ((ln + 1) * BASE_PERIOD) >> lvl;
      return (r < 1) ? 1 : r;
   endfunction

   task automatic model_reset();
      m_phase = P_RST;
      m_rr = 0;
      for (int i = 0; i < LANES; i++) begin
         m_cnt[i] = reload_of(i, 0);
         m_pend[i] = 1'b0;
      end
      e_clr = 0; e_sel = 3; e_lane = 0; e_en = (1 << LANES) - 1; e_busy = 0; e_ovr = 0;
   endtask

   task automatic model_step(input bit s_n, input bit p_n, input bit t_n, input int lvl);
      int g;
      e_sel = 3;
      e_en  = (1 << LANES) - 1;
      case (m_phase)
         P_RST:  m_phase = P_CLR;
         P_CLR: begin
            for (int i = 0; i < LANES; i++) m_cnt[i] = reload_of(i, lvl);
            m_phase = P_IDLE;
         end
         P_IDLE: if (!s_n) m_phase = P_INIT;
         P_INIT: begin
            for (int i = 0; i < LANES; i++) begin
               m_cnt[i] = reload_of(i, lvl);
               m_pend[i] = 1'b0;
            end
            e_ovr = 0;
            m_phase = P_HOLD;
         end
         P_HOLD: if (s_n) m_phase = P_RUN;
         P_RUN: begin
            if (!p_n) m_phase = P_PAUSE;
            else if (!s_n) m_phase = P_INIT;
            else begin
               g = -1;
               for (int k = 0; k < LANES; k++) begin
                  if (g < 0 && m_pend[(m_rr + k) % LANES]) g = (m_rr + k) % LANES;
               end
               if (g >= 0) begin
                  m_pend[g] = 1'b0;
                  m_rr   = (g + 1) % LANES;
                  e_lane = g;
                  e_en   = ((1 << LANES) - 1) & ~(1 << g);
                  e_sel  = (g % 2 == 1) ? 1 : 2;
               end
               if (!t_n) begin
                  for (int i = 0; i < LANES; i++) begin
                     if (m_cnt[i] == 1) begin
                        m_cnt[i] = reload_of(i, lvl);
                        if (m_pend[i]) e_ovr = 1;
                        m_pend[i] = 1'b1;
                     end else begin
                        m_cnt[i] = m_cnt[i] - 1;
                     end
                  end
               end
            end
         end
         P_PAUSE: begin
            if (!s_n) m_phase = P_INIT;
            else if (p_n) m_phase = P_RUN;
         end
         default: m_phase = P_RST;
      endcase
      e_clr = (m_phase == P_CLR || m_phase == P_INIT) ? 0 : 1;
      e_busy = 0;
      for (int i = 0; i < LANES; i++) if (m_pend[i]) e_busy = 1;
   endtask

   // Advance the model on every edge and compare all outputs just after it.
   always @(posedge clk) begin
      if (rst) model_reset();
      else model_step(start_n, pause_n, tick_n, int'(level));
      #1;
      check("m_clear", 32'(clear_n), 32'(e_clr));
      check("m_sel",   32'(sel),     32'(e_sel));
      check("m_lane",  32'(lane),    32'(e_lane));
      check("m_en",    32'(en_n),    32'(e_en));
      check("m_busy",  32'(busy),    32'(e_busy));
      check("m_ovr",   32'(ovr),     32'(e_ovr));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick_pulse();
      tick_n = 1'b0;
      @(negedge clk);
      tick_n = 1'b1;
   endtask

   task automatic restart();
      start_n = 1'b0;
      repeat (2) @(negedge clk);
      start_n = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   // Record up to two shifts seen over the next four cycles.
   task automatic collect(output int n, output int l0, output int l1, output int c0, output int c1);
      n = 0; l0 = -1; l1 = -1; c0 = -1; c1 = -1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (sel != 2'b11) begin
            if (n == 0) begin l0 = int'(lane); c0 = c; end
            else if (n == 1) begin l1 = int'(lane); c1 = c; end
            n++;
         end
      end
   endtask

   initial begin
      int lows, n, l0, l1, c0, c1, hold_start;
      int exp_l [4];
      bit found;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_clear", 32'(clear_n), 0);
      check("rst_sel",   32'(sel),     3);
      check("rst_lane",  32'(lane),    0);
      check("rst_en",    32'(en_n),    32'hF);
      check("rst_busy",  32'(busy),    0);
      check("rst_ovr",   32'(ovr),     0);
      rst = 1'b0;

      // Boot: clear low only in CLEAR, idle hold afterwards
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check("boot_clear", 32'(clear_n), (c == 0) ? 0 : 1);
         check("boot_sel",   32'(sel), 3);
         check("boot_en",    32'(en_n), 32'hF);
      end

      // Start pressed 3 cycles: exactly one clear pulse
      start_n = 1'b0;
      lows = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (!clear_n) lows++;
         if (c == 2) start_n = 1'b1;
      end
      check("init_clear_pulses", 32'(lows), 1);

      // Level 0: lane 0 shifts left after tick 8
      for (int t = 1; t <= 7; t++) begin
         tick_pulse();
         repeat (2) @(negedge clk);
      end
      tick_pulse();
      check("t8_busy", 32'(busy), 1);
      check("t8_sel_pre", 32'(sel), 3);
      @(negedge clk);
      check("t8_sel", 32'(sel), 2);
      check("t8_en",  32'(en_n), 32'hE);
      check("t8_lane", 32'(lane), 0);
      @(negedge clk);
      check("t8_sel_post", 32'(sel), 3);
      check("t8_en_post",  32'(en_n), 32'hF);

      // Level 3: reloads 1,2,3,4; all expire at tick 12, rr starts at lane 1
      level = 2'd3;
      restart();
      for (int t = 1; t <= 11; t++) begin
         tick_pulse();
         repeat (5) @(negedge clk);
      end
      tick_pulse();
      check("t12_busy0", 32'(busy), 1);
      exp_l = '{1, 2, 3, 0};
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("t12_lane", 32'(lane), 32'(exp_l[j]));
         check("t12_sel",  32'(sel), (exp_l[j] % 2 == 1) ? 1 : 2);
         check("t12_busy", 32'(busy), (j < 3) ? 1 : 0);
      end
      repeat (5) @(negedge clk);

      // Pause with lanes 0 and 1 pending; ticks during pause are ignored
      tick_pulse();
      repeat (5) @(negedge clk);
      tick_pulse();
      pause_n = 1'b0;
      tick_n  = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("pause_sel",  32'(sel), 3);
         check("pause_busy", 32'(busy), 1);
      end
      pause_n = 1'b1;
      tick_n  = 1'b1;
      collect(n, l0, l1, c0, c1);
      check("unpause_n",   32'(n), 2);
      check("unpause_l0",  32'(l0), 1);
      check("unpause_l1",  32'(l1), 0);
      check("unpause_gap", 32'(c1 - c0), 1);

      // Frozen counters: next tick expires lanes 0 and 2, granted 2 then 0
      repeat (3) @(negedge clk);
      tick_pulse();
      collect(n, l0, l1, c0, c1);
      check("t15_n",  32'(n), 2);
      check("t15_l0", 32'(l0), 2);
      check("t15_l1", 32'(l1), 0);
      check("t15_c0", 32'(c0), 0);

      // Overrun: ticks every cycle, sticky until INIT
      repeat (4) @(negedge clk);
      check("ovr_before", 32'(ovr), 0);
      tick_n = 1'b0;
      repeat (10) @(negedge clk);
      tick_n = 1'b1;
      check("ovr_set", 32'(ovr), 1);
      pause_n = 1'b0;
      repeat (3) @(negedge clk);
      check("ovr_pause", 32'(ovr), 1);
      pause_n = 1'b1;
      repeat (8) @(negedge clk);
      check("ovr_sticky", 32'(ovr), 1);
      restart();
      check("ovr_cleared", 32'(ovr), 0);

      // Reset during a left shift returns outputs at once
      tick_n = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge clk);
         if (sel == 2'b10) found = 1'b1;
      end
      tick_n = 1'b1;
      check("rst_wait_sel", 32'(sel), 2);
      if (found) begin
         rst = 1'b1;
         #1;
         check("arst_sel",   32'(sel), 3);
         check("arst_en",    32'(en_n), 32'hF);
         check("arst_clear", 32'(clear_n), 0);
         check("arst_busy",  32'(busy), 0);
         check("arst_lane",  32'(lane), 0);
         @(negedge clk);
         rst = 1'b0;
      end else begin
         rst = 1'b1;
         @(negedge clk);
         rst = 1'b0;
      end

      // Randomized run against the model
      start_n = 1'b0;
      hold_start = 2;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         tick_n = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 39) == 0) pause_n = ~pause_n;
         if (hold_start > 0) begin
            hold_start--;
            if (hold_start == 0) start_n = 1'b1;
         end else if ($urandom_range(0, 149) == 0) begin
            start_n = 1'b0;
            hold_start = int'($urandom_range(1, 4));
         end
         if ($urandom_range(0, 99) == 0) level = 2'($urandom_range(0, 3));
      end
      tick_n = 1'b1;
      repeat (5) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
